spike_timestep_scheduler: RTL and testbench



---
 rtl/spike_timestep_scheduler_if.sv | 25 ++
 rtl/spike_timestep_scheduler.sv | 161 ++++++++++++++++
 tb/tb_spike_timestep_scheduler.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_timestep_scheduler_if.sv
// Spike event handshake between the timestep scheduler (master) and the
// source-event consumer (slave).
interface spike_timestep_scheduler_if #(
   parameter int IDX_W  = 5,
   parameter int ADDR_W = 12
);
   logic              ev_valid;
   logic              ev_ready;
   logic [IDX_W-1:0]  ev_neuron_idx;
   logic [ADDR_W-1:0] ev_address;

   modport master (
      output ev_valid,
      output ev_neuron_idx,
      output ev_address,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  ev_neuron_idx,
      input  ev_address,
      output ev_ready
   );
endinterface

// File: rtl/spike_timestep_scheduler.sv
// Sequences one SNN timestep: clear pulse, spike snapshot, then one source
// event per captured spike over valid/ready, closed by a done pulse.
module spike_timestep_scheduler #(
   parameter int NUM_NEURONS  = 30,
   parameter int IDX_W        = 5,
   parameter int ADDR_W       = 12,
   parameter int COUNT_W      = 6,
   parameter int CLEAR_CYCLES = 2
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic                   start,
   input  logic [NUM_NEURONS-1:0] spikes,
   input  logic [ADDR_W-1:0]      base_address,
   output logic                   clear_ni,
   output logic                   set_ni,
   spike_timestep_scheduler_if.master ev,
   output logic                   busy,
   output logic                   done,
   output logic [COUNT_W-1:0]     spike_count,
   output logic                   overrun
);

   localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_CAPTURE,
      S_DISPATCH,
      S_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       clr_cnt_q, clr_cnt_d;
   logic [NUM_NEURONS-1:0] pending_q, pending_d;
   logic [ADDR_W-1:0]      base_q, base_d;
   logic [COUNT_W-1:0]     spike_count_q, spike_count_d;
   logic                   overrun_q, overrun_d;
   logic                   clear_ni_q, clear_ni_d;
   logic                   set_ni_q, set_ni_d;
   logic                   ev_valid_q, ev_valid_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_NEURONS-1:0] v);
      logic [IDX_W-1:0] r;
      r = '0;
      // Scan downward so the final hit is the lowest set bit.
      for (int unsigned i = NUM_NEURONS; i > 0; i--) begin
         if (v[i-1]) r = IDX_W'(i - 1);
      end
      return r;
   endfunction

   function automatic logic [COUNT_W-1:0] popcount(input logic [NUM_NEURONS-1:0] v);
      logic [COUNT_W-1:0] c;
      c = '0;
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
         c = c + COUNT_W'(v[i]);
      end
      return c;
   endfunction

   always_comb begin
      state_d       = state_q;
      clr_cnt_d     = clr_cnt_q;
      pending_d     = pending_q;
      base_d        = base_q;
      spike_count_d = spike_count_q;
      overrun_d     = overrun_q;
      idx_d         = idx_q;

      if (start && (state_q == S_CLEAR || state_q == S_CAPTURE || state_q == S_DISPATCH)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_CLEAR;
               clr_cnt_d = CNT_W'(CLEAR_CYCLES - 1);
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLEAR: begin
            if (clr_cnt_q == '0) state_d = S_CAPTURE;
            else                 clr_cnt_d = clr_cnt_q - 1'b1;
         end
         S_CAPTURE: begin
            pending_d     = spikes;
            base_d        = base_address;
            spike_count_d = popcount(spikes);
            idx_d         = lowest_idx(spikes);
            state_d       = (spikes == '0) ? S_DONE : S_DISPATCH;
         end
         S_DISPATCH: begin
            if (ev.ev_ready) begin
               pending_d = pending_q & ~(NUM_NEURONS'(1) << idx_q);
               idx_d     = lowest_idx(pending_d);
               if (pending_d == '0) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      clear_ni_d = (state_d == S_CLEAR);
      set_ni_d   = (state_d == S_DISPATCH);
      ev_valid_d = (state_d == S_DISPATCH);
      busy_d     = (state_d == S_CLEAR) || (state_d == S_CAPTURE) || (state_d == S_DISPATCH);
      done_d     = (state_d == S_DONE);
      addr_d     = base_d + ADDR_W'(idx_d);
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q       <= S_IDLE;
         clr_cnt_q     <= '0;
         pending_q     <= '0;
         base_q        <= '0;
         spike_count_q <= '0;
         overrun_q     <= 1'b0;
         clear_ni_q    <= 1'b0;
         set_ni_q      <= 1'b0;
         ev_valid_q    <= 1'b0;
         idx_q         <= '0;
         addr_q        <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         clr_cnt_q     <= clr_cnt_d;
         pending_q     <= pending_d;
         base_q        <= base_d;
         spike_count_q <= spike_count_d;
         overrun_q     <= overrun_d;
         clear_ni_q    <= clear_ni_d;
         set_ni_q      <= set_ni_d;
         ev_valid_q    <= ev_valid_d;
         idx_q         <= idx_d;
         addr_q        <= addr_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign clear_ni         = clear_ni_q;
   assign set_ni           = set_ni_q;
   assign ev.ev_valid      = ev_valid_q;
   assign ev.ev_neuron_idx = idx_q;
   assign ev.ev_address    = addr_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign spike_count      = spike_count_q;
   assign overrun          = overrun_q;

endmodule

// File: tb/tb_spike_timestep_scheduler.sv
// Randomized bench for spike_timestep_scheduler against a timeline/queue model
// of one timestep, plus literal expectations for the directed scenarios.
module tb_spike_timestep_scheduler;

   localparam int C = 2;

   logic        CLK = 1'b0;
   logic        RESET_N;
   logic        start;
   logic [29:0] spikes;
   logic [11:0] base_address;
   logic        clear_ni, set_ni, busy, done, overrun;
   logic [5:0]  spike_count;

   spike_timestep_scheduler_if #(.IDX_W(5), .ADDR_W(12)) ev_if ();

   spike_timestep_scheduler #(
      .NUM_NEURONS(30), .IDX_W(5), .ADDR_W(12), .COUNT_W(6), .CLEAR_CYCLES(C)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .start(start), .spikes(spikes),
      .base_address(base_address), .clear_ni(clear_ni), .set_ni(set_ni),
      .ev(ev_if), .busy(busy), .done(done), .spike_count(spike_count),
      .overrun(overrun)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int s_cyc = 0;
   int rmode = 3;
   bit jitter = 0;
   bit chk_en = 0;

   // Model state: timeline position and queue of indices still to send.
   bit          mact = 0, mcap = 0, mdone = 0, movr = 0;
   int          mt = 0, mcount = 0;
   logic [11:0] mbase = '0;
   int          mq[$];

   // Observations from the compare process.
   int          log_idx[$];
   logic [11:0] log_addr[$];
   int          clr_hi = 0;
   int          done_seen = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model update on every rising edge from the inputs sampled there.
   initial begin
      forever begin
         @(posedge CLK);
         cyc++;
         if (!RESET_N) begin
            mact = 0; mcap = 0; mdone = 0; movr = 0; mcount = 0; mt = 0;
            mq.delete();
         end else begin
            mdone = 0;
            if (mact) begin
               if (start) movr = 1;
               if (!mcap) begin
                  mt++;
                  if (mt == C + 1) begin
                     mq.delete();
                     for (int i = 0; i < 30; i++) if (spikes[i]) mq.push_back(i);
                     mbase  = base_address;
                     mcount = mq.size();
                     mcap   = 1;
                     if (mq.size() == 0) begin mact = 0; mdone = 1; end
                  end
               end else if (ev_if.ev_ready) begin
                  void'(mq.pop_front());
                  if (mq.size() == 0) begin mact = 0; mdone = 1; end
               end
            end else if (start) begin
               mact = 1; mcap = 0; mt = 0;
            end
         end
      end
   end

   // Compare process: every falling edge once reset has been applied.
   initial begin
      logic        e_valid;
      logic [11:0] e_addr;
      forever begin
         @(negedge CLK);
         if (chk_en) begin
            e_valid = mact && mcap && (mq.size() > 0);
            chk("busy", busy, mact);
            chk("clear_ni", clear_ni, mact && !mcap && (mt < C));
            chk("set_ni", set_ni, e_valid);
            chk("ev_valid", ev_if.ev_valid, e_valid);
            chk("done", done, mdone);
            chk("spike_count", spike_count, mcount);
            chk("overrun", overrun, movr);
            if (e_valid) begin
               e_addr = mbase + 12'(mq[0]);
               chk("ev_idx", ev_if.ev_neuron_idx, mq[0]);
               chk("ev_addr", ev_if.ev_address, e_addr);
            end
            if (ev_if.ev_valid === 1'b1 && ev_if.ev_ready === 1'b1) begin
               log_idx.push_back(int'(ev_if.ev_neuron_idx));
               log_addr.push_back(ev_if.ev_address);
            end
            if (clear_ni === 1'b1) clr_hi++;
            if (done === 1'b1) done_seen++;
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
      case (rmode)
         0: ev_if.ev_ready = 1'b1;
         1: ev_if.ev_ready = ~ev_if.ev_ready;
         2: ev_if.ev_ready = 1'($urandom_range(0, 1));
         default: ev_if.ev_ready = 1'b0;
      endcase
      if (jitter) spikes = 30'($urandom);
   endtask

   task automatic start_ts();
      start = 1'b1;
      step();
      s_cyc = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int delta);
      bit found;
      found = 0;
      delta = -1;
      for (int i = 0; i < budget && !found; i++) begin
         step();
         if (done === 1'b1) begin found = 1; delta = cyc - s_cyc; end
      end
      if (!found) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done within %0d cycles, required done", budget);
      end
   endtask

   task automatic clear_logs();
      log_idx.delete();
      log_addr.delete();
      clr_hi = 0;
      done_seen = 0;
   endtask

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: got timeout, required completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      RESET_N = 1'b0; start = 1'b0; spikes = '0; base_address = '0;
      ev_if.ev_ready = 1'b0;
      rmode = 3;
      repeat (3) step();
      chk_en = 1;
      chk("rst_busy", busy, 0);
      chk("rst_valid", ev_if.ev_valid, 0);
      chk("rst_count", spike_count, 0);
      RESET_N = 1'b1;
      step();

      // 1: three spikes, ready tied high
      rmode = 0; spikes = 30'h25; base_address = 12'h100;
      step();
      clear_logs();
      start_ts();
      wait_done(50, d);
      chk("t1_done_edge", d, 6);
      chk("t1_clear_len", clr_hi, 2);
      chk("t1_count", spike_count, 3);
      chk("t1_nevents", log_addr.size(), 3);
      if (log_addr.size() == 3) begin
         chk("t1_a0", log_addr[0], 12'h100);
         chk("t1_a1", log_addr[1], 12'h102);
         chk("t1_a2", log_addr[2], 12'h105);
         chk("t1_i2", log_idx[2], 5);
      end
      step();

      // 2: no spikes
      spikes = '0;
      clear_logs();
      start_ts();
      wait_done(50, d);
      chk("t2_done_edge", d, 3);
      chk("t2_count", spike_count, 0);
      chk("t2_nevents", log_addr.size(), 0);
      step();

      // 3: all spikes, ready toggling
      rmode = 1; spikes = '1; base_address = 12'h040;
      clear_logs();
      start_ts();
      wait_done(200, d);
      chk("t3_count", spike_count, 30);
      chk("t3_nevents", log_idx.size(), 30);
      for (int i = 0; i < log_idx.size(); i++) chk("t3_order", log_idx[i], i);
      step();

      // 4: address wrap
      rmode = 2; spikes = 30'hB; base_address = 12'hFFE;
      clear_logs();
      start_ts();
      wait_done(200, d);
      chk("t4_nevents", log_addr.size(), 3);
      if (log_addr.size() == 3) begin
         chk("t4_a0", log_addr[0], 12'hFFE);
         chk("t4_a1", log_addr[1], 12'hFFF);
         chk("t4_a2", log_addr[2], 12'h001);
      end
      step();

      // 5: start during dispatch, then start during the done cycle
      rmode = 0; spikes = 30'h3C0; base_address = 12'h020;
      start_ts();
      repeat (4) step();
      start = 1'b1; step(); start = 1'b0;
      chk("t5_overrun", overrun, 1);
      wait_done(50, d);
      chk("t5_done_edge", d, 7);
      start_ts();
      chk("t5_b2b_busy", busy, 1);
      chk("t5_b2b_clear", clear_ni, 1);
      wait_done(50, d);
      chk("t5_done_edge2", d, 7);
      chk("t5_overrun_sticky", overrun, 1);
      step();

      // 6: reset mid-dispatch
      spikes = 30'hF;
      start_ts();
      repeat (5) step();
      chk("t6_pre_set", set_ni, 1);
      RESET_N = 1'b0;
      step();
      chk("t6_busy", busy, 0);
      chk("t6_set", set_ni, 0);
      chk("t6_valid", ev_if.ev_valid, 0);
      chk("t6_overrun", overrun, 0);
      chk("t6_count", spike_count, 0);
      RESET_N = 1'b1;
      clear_logs();
      repeat (5) step();
      chk("t6_no_done", done_seen, 0);
      spikes = 30'h5;
      start_ts();
      wait_done(50, d);
      chk("t6_clean_edge", d, 5);
      chk("t6_clean_count", spike_count, 2);
      step();

      // Randomized timesteps, with spike jitter and occasional overlapping starts
      for (int n = 0; n < 25; n++) begin
         rmode = $urandom_range(0, 2);
         base_address = 12'($urandom);
         spikes = 30'($urandom) & 30'($urandom);
         jitter = ($urandom_range(0, 2) == 0);
         start_ts();
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(0, 6)) step();
            if (busy === 1'b1) begin start = 1'b1; step(); start = 1'b0; end
         end
         wait_done(400, d);
         repeat ($urandom_range(0, 3)) step();
      end
      jitter = 0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
